// File: rtl/coproc_issue_ctrl.sv
// coproc_issue_ctrl: issues one EX coprocessor op to the FPU or crypto core, stalls until done/flush/timeout, writes back
module coproc_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_unit,
  input  logic [3:0]      ex_op,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_a,
  input  logic [XLEN-1:0] ex_b,
  input  logic            flush,
  output logic            fpu_start,
  input  logic            fpu_done,
  input  logic [XLEN-1:0] fpu_result,
  output logic            crypto_start,
  input  logic            crypto_done,
  input  logic [XLEN-1:0] crypto_result,
  output logic [3:0]      cp_op,
  output logic [XLEN-1:0] cp_a,
  output logic [XLEN-1:0] cp_b,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            timeout_err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
  state_t          state;
  logic            unit;
  logic [CW-1:0]   cnt;
  logic            sel_done;
  logic [XLEN-1:0] sel_res;
  // only the latched unit's handshake is ever looked at
  assign sel_done     = unit ? crypto_done : fpu_done;
  assign sel_res      = unit ? crypto_result : fpu_result;
  assign fpu_start    = (state == ISSUE) && !unit;
  assign crypto_start = (state == ISSUE) && unit;
  assign stall        = ((state == IDLE) && ex_valid && !flush) || (state == ISSUE) || (state == WAIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      unit        <= 1'b0;
      cnt         <= '0;
      cp_op       <= '0;
      cp_a        <= '0;
      cp_b        <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ex_valid && !flush) begin
          unit  <= ex_unit;
          cp_op <= ex_op;
          wb_rd <= ex_rd;
          cp_a  <= ex_a;
          cp_b  <= ex_b;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= flush ? IDLE : WAIT;
        end
        WAIT: if (flush) begin
          state <= IDLE;
        end else if (sel_done) begin
          wb_data  <= sel_res;
          wb_valid <= 1'b1;
          state    <= WB;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_err <= 1'b1;
          wb_data     <= '0;
          wb_valid    <= 1'b0;
          state       <= WB;
        end else begin
          cnt <= cnt + 1'b1;
        end
        WB: begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coproc_issue_ctrl.sv
// tb_coproc_issue_ctrl: per-cycle directed vectors against coproc_issue_ctrl with TIMEOUT=8
module tb_coproc_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_unit, flush, fpu_done, crypto_done;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a, ex_b, fpu_result, crypto_result;
  logic        fpu_start, crypto_start, stall, wb_valid, timeout_err;
  logic [3:0]  cp_op;
  logic [31:0] cp_a, cp_b, wb_data;
  logic [4:0]  wb_rd;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic ev, un; logic [3:0] op; logic [4:0] rd; logic [31:0] a, b;
    logic fl, fd; logic [31:0] fr; logic cd; logic [31:0] cr;
    logic xfs, xcs, xst, xwv, chk; logic [4:0] xrd; logic [31:0] xwd; logic [3:0] xop; logic xte;
  } vec_t;

  coproc_issue_ctrl #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_unit(ex_unit), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .flush(flush), .fpu_start(fpu_start), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .crypto_start(crypto_start), .crypto_done(crypto_done),
    .crypto_result(crypto_result), .cp_op(cp_op), .cp_a(cp_a), .cp_b(cp_b), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    ex_valid = v.ev; ex_unit = v.un; ex_op = v.op; ex_rd = v.rd; ex_a = v.a; ex_b = v.b;
    flush = v.fl; fpu_done = v.fd; fpu_result = v.fr; crypto_done = v.cd; crypto_result = v.cr;
    #1;
    cmp({nm, " fpu_start"}, 32'(fpu_start), 32'(v.xfs));
    cmp({nm, " crypto_start"}, 32'(crypto_start), 32'(v.xcs));
    cmp({nm, " stall"}, 32'(stall), 32'(v.xst));
    cmp({nm, " wb_valid"}, 32'(wb_valid), 32'(v.xwv));
    cmp({nm, " cp_op"}, 32'(cp_op), 32'(v.xop));
    cmp({nm, " timeout_err"}, 32'(timeout_err), 32'(v.xte));
    if (v.chk) begin
      cmp({nm, " wb_rd"}, 32'(wb_rd), 32'(v.xrd));
      cmp({nm, " wb_data"}, wb_data, v.xwd);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    cmp({nm, " outs"}, {25'(0), fpu_start, crypto_start, stall, wb_valid, timeout_err, 2'b00}, 32'h0);
    cmp({nm, " cp_op/wb_rd"}, {23'(0), cp_op, wb_rd}, 32'h0);
    cmp({nm, " cp_a"}, cp_a, 32'h0);
    cmp({nm, " cp_b"}, cp_b, 32'h0);
    cmp({nm, " wb_data"}, wb_data, 32'h0);
  endtask

  initial begin
    vec_t tbl[$];
    localparam logic [31:0] A = 32'h3F800000, B = 32'h40000000;
    // ev un op rd a b | fl fd fr cd cr | xfs xcs xst xwv chk xrd xwd xop xte
    tbl.push_back('{1,0,3,7,A,B, 0,0,0,0,0, 0,0,1,0,0,0,0,0,0});
    tbl.push_back('{1,0,3,7,A,B, 0,0,0,0,0, 1,0,1,0,0,0,0,3,0});
    tbl.push_back('{1,0,3,7,A,B, 0,0,0,0,0, 0,0,1,0,0,0,0,3,0});
    tbl.push_back('{1,0,3,7,A,B, 0,0,0,0,0, 0,0,1,0,0,0,0,3,0});
    tbl.push_back('{1,0,3,7,A,B, 0,1,32'h40400000,0,0, 0,0,1,0,0,0,0,3,0});
    tbl.push_back('{1,0,3,7,A,B, 0,0,0,0,0, 0,0,0,1,1,7,32'h40400000,3,0});
    tbl.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,3,0});
    tbl.push_back('{1,1,9,3,1,2, 0,0,0,0,0, 0,0,1,0,0,0,0,3,0});
    tbl.push_back('{1,1,9,3,1,2, 0,0,0,0,0, 0,1,1,0,0,0,0,9,0});
    tbl.push_back('{1,1,9,3,1,2, 0,1,32'h11111111,0,0, 0,0,1,0,0,0,0,9,0});
    tbl.push_back('{1,1,9,3,1,2, 0,0,0,1,32'hDEADBEEF, 0,0,1,0,0,0,0,9,0});
    tbl.push_back('{1,1,9,3,1,2, 0,0,0,0,0, 0,0,0,1,1,3,32'hDEADBEEF,9,0});
    tbl.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,9,0});
    tbl.push_back('{1,0,1,5,4,5, 0,0,0,0,0, 0,0,1,0,0,0,0,9,0});
    tbl.push_back('{1,0,1,5,4,5, 0,0,0,0,0, 1,0,1,0,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0, 1,1,32'h5555,0,0, 0,0,1,0,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0, 0,1,32'h6666,0,0, 0,0,0,0,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,5,32'hDEADBEEF,1,0});
    tbl.push_back('{1,0,2,9,0,0, 1,0,0,0,0, 0,0,0,0,0,0,0,1,0});
    tbl.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,5,32'hDEADBEEF,1,0});
    ex_valid = 0; ex_unit = 0; ex_op = 0; ex_rd = 0; ex_a = 0; ex_b = 0; flush = 0;
    fpu_done = 0; fpu_result = 0; crypto_done = 0; crypto_result = 0;
    rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));
    // crypto unit silent: WB with wb_valid=0 at cycle TIMEOUT+2 = 10
    for (int c = 0; c < 12; c++)
      apply('{c < 11, 1, 4, 12, 32'hC0, 32'hC1, 0, 0, 0, 0, 0,
              0, c == 1, c < 10, 0, c == 10, 12, 0, (c == 0) ? 4'd1 : 4'd4, c >= 10}, $sformatf("timeout%0d", c));
    // back-to-back with ex_valid held; timeout_err must stay set
    tbl.delete();
    tbl.push_back('{1,0,6,1,10,20, 0,0,0,0,0, 0,0,1,0,0,0,0,4,1});
    tbl.push_back('{1,0,6,1,10,20, 0,0,0,0,0, 1,0,1,0,0,0,0,6,1});
    tbl.push_back('{1,0,6,1,10,20, 0,1,32'hAAAA0001,0,0, 0,0,1,0,0,0,0,6,1});
    tbl.push_back('{1,0,6,1,10,20, 0,0,0,0,0, 0,0,0,1,1,1,32'hAAAA0001,6,1});
    tbl.push_back('{1,0,7,2,30,40, 0,0,0,0,0, 0,0,1,0,0,0,0,6,1});
    tbl.push_back('{1,0,7,2,30,40, 0,0,0,0,0, 1,0,1,0,0,0,0,7,1});
    tbl.push_back('{1,0,7,2,30,40, 0,1,32'hAAAA0002,0,0, 0,0,1,0,0,0,0,7,1});
    tbl.push_back('{1,0,7,2,30,40, 0,0,0,0,0, 0,0,0,1,1,2,32'hAAAA0002,7,1});
    tbl.push_back('{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,7,1});
    tbl.push_back('{1,0,8,4,32'h77,32'h88, 0,0,0,0,0, 0,0,1,0,0,0,0,7,1});
    tbl.push_back('{1,0,8,4,32'h77,32'h88, 0,0,0,0,0, 1,0,1,0,0,0,0,8,1});
    foreach (tbl[i]) apply(tbl[i], $sformatf("b2b%0d", i));
    cmp("b2b cp_b", cp_b, 32'h88);
    // now in WAIT: asynchronous reset between edges
    ex_valid = 0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tbl.delete();
    tbl.push_back('{1,1,8,4,32'h77,32'h88, 0,0,0,0,0, 0,0,1,0,0,0,0,0,0});
    tbl.push_back('{1,1,8,4,32'h77,32'h88, 0,0,0,0,0, 0,1,1,0,0,0,0,8,0});
    tbl.push_back('{1,1,8,4,32'h77,32'h88, 0,0,0,1,32'h12345678, 0,0,1,0,0,0,0,8,0});
    tbl.push_back('{1,1,8,4,32'h77,32'h88, 0,0,0,0,0, 0,0,0,1,1,4,32'h12345678,8,0});
    foreach (tbl[i]) apply(tbl[i], $sformatf("post_reset%0d", i));
    cmp("post_reset cp_a", cp_a, 32'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
